// File: rtl/bit_string_printer_if.sv
// Request and UART-tx handshake bundle for bit_string_printer.
// master: requester/UART side; slave: the printer.
interface bit_string_printer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] value;
    logic             new_value;
    logic             busy;
    logic [7:0]       tx_data;
    logic             new_tx_data;
    logic             tx_busy;

    modport master (
        output value,
        output new_value,
        output tx_busy,
        input  busy,
        input  tx_data,
        input  new_tx_data
    );

    modport slave (
        input  value,
        input  new_value,
        input  tx_busy,
        output busy,
        output tx_data,
        output new_tx_data
    );
endinterface

// File: rtl/bit_string_printer.sv
// Prints a WIDTH-bit value over the UART tx handshake as ASCII '0'/'1' characters,
// optionally followed by CR LF.
module bit_string_printer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          NEWLINE   = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    bit_string_printer_if.slave bus
);
    localparam int unsigned     IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [7:0]      CH_ZERO  = 8'h30;
    localparam logic [7:0]      CH_ONE   = 8'h31;
    localparam logic [7:0]      CH_CR    = 8'h0D;
    localparam logic [7:0]      CH_LF    = 8'h0A;

    typedef enum logic [1:0] {
        IDLE,
        SEND_BIT,
        SEND_CR,
        SEND_LF
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] shreg;
    logic             cur_bit;
    logic             tx_ok;
    logic [7:0]       tx_char;

    assign tx_ok   = !bus.tx_busy;
    // The character to print always sits at the leading end of the shift register.
    assign cur_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            shreg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.new_value) begin
                        shreg <= bus.value;
                        idx   <= '0;
                        state <= SEND_BIT;
                    end
                end
                SEND_BIT: begin
                    if (tx_ok) begin
                        shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= NEWLINE ? SEND_CR : IDLE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                SEND_CR: begin
                    if (tx_ok) begin
                        state <= SEND_LF;
                    end
                end
                SEND_LF: begin
                    if (tx_ok) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Character decode from the registered state; idle presents 8'h00.
    always_comb begin
        tx_char = 8'h00;
        case (state)
            SEND_BIT: tx_char = cur_bit ? CH_ONE : CH_ZERO;
            SEND_CR:  tx_char = CH_CR;
            SEND_LF:  tx_char = CH_LF;
            default:  tx_char = 8'h00;
        endcase
    end

    assign bus.tx_data     = tx_char;
    assign bus.busy        = (state != IDLE);
    assign bus.new_tx_data = (state != IDLE) && tx_ok;

endmodule

// File: tb/tb_bit_string_printer.sv
// Scoreboard bench: dut0 = defaults (MSB first, CR LF), dut1 = LSB first, no trailer.
module tb_bit_string_printer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] value_r [2];
    logic       nv_r    [2];
    logic       txb_r   [2];
    logic       busy_w  [2];
    logic [7:0] txd_w   [2];
    logic       ntx_w   [2];

    bit_string_printer_if #(.WIDTH(8)) if0 ();
    bit_string_printer_if #(.WIDTH(8)) if1 ();

    assign if0.value = value_r[0];
    assign if0.new_value = nv_r[0];
    assign if0.tx_busy = txb_r[0];
    assign if1.value = value_r[1];
    assign if1.new_value = nv_r[1];
    assign if1.tx_busy = txb_r[1];
    assign busy_w[0] = if0.busy;
    assign busy_w[1] = if1.busy;
    assign txd_w[0] = if0.tx_data;
    assign txd_w[1] = if1.tx_data;
    assign ntx_w[0] = if0.new_tx_data;
    assign ntx_w[1] = if1.new_tx_data;

    bit_string_printer #(.WIDTH(8), .MSB_FIRST(1'b1), .NEWLINE(1'b1)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave));
    bit_string_printer #(.WIDTH(8), .MSB_FIRST(1'b0), .NEWLINE(1'b0)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc [2] = '{-1, -1};
    int last_str [2] = '{0, 0};
    int len [2] = '{10, 8};
    int mode [2] = '{0, 0};     // UART model: 0 always ready, 1 busy 5 cycles per char, 2 random
    int hold [2] = '{0, 0};
    logic strobe_seen [2] = '{1'b0, 1'b0};
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void qpush(input int d, input logic [7:0] c);
        if (d == 0) q0.push_back(c); else q1.push_back(c);
    endfunction

    function automatic logic [7:0] qpop(input int d);
        return (d == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    task automatic chk(input int d, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL dut%0d %s @cycle %0d: got %0h, required %0h", d, nm, cyc, act, exp);
        end
    endtask

    // Reference: the string a value should produce on each DUT.
    task automatic push_expected(input int d, input logic [7:0] v);
        logic b;
        for (int i = 0; i < 8; i++) begin
            b = (d == 1) ? v[i] : v[7-i];
            qpush(d, b ? 8'h31 : 8'h30);
        end
        if (d == 0) begin
            qpush(d, 8'h0D);
            qpush(d, 8'h0A);
        end
    endtask

    // A request is honoured only if every character of the previous print went out in an earlier cycle.
    task automatic request(input int d, input logic [7:0] v);
        value_r[d] = v;
        nv_r[d] = 1'b1;
        if (qsize(d) == 0) begin
            push_expected(d, v);
            acc_cyc[d] = cyc;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        nv_r[0] = 1'b0;
        nv_r[1] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (qsize(d) != 0 && n < 400) begin
            tick();
            n++;
        end
        n_cmp++;
        if (qsize(d) != 0) begin
            n_bad++;
            $display("FAIL dut%0d drain_timeout: %0d characters still outstanding, required 0", d, qsize(d));
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous reset discards whatever was still expected.
    always @(posedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
        end
    end

    // UART model driving tx_busy.
    initial begin
        txb_r[0] = 1'b0;
        txb_r[1] = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (strobe_seen[d]) hold[d] = 5;
                strobe_seen[d] = 1'b0;
                case (mode[d])
                    1: begin
                        txb_r[d] = (hold[d] > 0);
                        if (hold[d] > 0) hold[d]--;
                    end
                    2: txb_r[d] = ($urandom_range(2) == 0);
                    default: txb_r[d] = 1'b0;
                endcase
            end
        end
    end

    // Monitor: compares every strobe with the scoreboard and checks idle/busy outputs.
    initial begin
        int sz;
        logic exp_busy;
        logic first;
        logic [7:0] e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                sz = qsize(d);
                exp_busy = (sz != 0) && (acc_cyc[d] != cyc);
                chk(d, "busy", 64'(busy_w[d]), 64'(exp_busy));
                if (ntx_w[d]) begin
                    strobe_seen[d] = 1'b1;
                    chk(d, "strobe_while_tx_busy", 64'(txb_r[d]), 64'(0));
                    if (sz == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL dut%0d unexpected_strobe @cycle %0d: got char %h, required no strobe", d, cyc, txd_w[d]);
                    end else begin
                        first = (sz == len[d]);
                        e = qpop(d);
                        chk(d, "tx_data", 64'(txd_w[d]), 64'(e));
                        if (mode[d] == 0)
                            chk(d, "strobe_cycle", 64'(cyc), 64'(first ? acc_cyc[d] + 1 : last_str[d] + 1));
                        else if (mode[d] == 1 && !first)
                            chk(d, "strobe_gap", 64'(cyc - last_str[d]), 64'(6));
                        last_str[d] = cyc;
                    end
                end else if (!exp_busy) begin
                    chk(d, "idle_tx_data", 64'(txd_w[d]), 64'(0));
                end
            end
        end
    end

    initial begin
        int n;
        value_r[0] = 8'h00;
        value_r[1] = 8'h00;
        nv_r[0] = 1'b0;
        nv_r[1] = 1'b0;

        // Reset held with new_value asserted: nothing may print.
        request(0, 8'hA5);
        request(1, 8'hA5);
        tick();
        request(0, 8'hA5);
        request(1, 8'hA5);
        tick();
        request(0, 8'hA5);
        request(1, 8'hA5);
        tick();
        rst = 1'b0;
        repeat (4) tick();

        // Back-to-back characters; LSB-first without trailer on dut1.
        request(0, 8'hA5);
        request(1, 8'h01);
        wait_idle(0);
        wait_idle(1);
        tick();

        // Slow UART.
        mode[0] = 1;
        request(0, 8'h3C);
        wait_idle(0);
        repeat (8) tick();
        mode[0] = 0;
        tick();

        // Requests mid-print and on the final strobe are dropped; the next one is taken.
        request(0, 8'h00);
        tick();
        request(0, 8'hFF);
        n = 0;
        do begin
            tick();
            n++;
        end while (qsize(0) != 1 && n < 50);
        request(0, 8'hFF);
        tick();
        request(0, 8'h5A);
        wait_idle(0);
        tick();

        // Reset mid-print, then a clean print.
        request(0, 8'hF0);
        n = 0;
        do begin
            tick();
            n++;
        end while (qsize(0) != 6 && n < 50);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        request(0, 8'h0F);
        wait_idle(0);
        tick();

        // Randomised traffic with a changing value bus and mixed UART behaviour.
        for (int seg = 0; seg < 8; seg++) begin
            mode[0] = int'($urandom_range(2));
            mode[1] = int'($urandom_range(2));
            tick();
            for (int c = 0; c < 250; c++) begin
                for (int d = 0; d < 2; d++) begin
                    value_r[d] = 8'($urandom);
                    if ($urandom_range(3) == 0) request(d, 8'($urandom));
                end
                tick();
            end
            wait_idle(0);
            wait_idle(1);
            repeat (8) tick();
        end

        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
